// File: rtl/pkt_stats_from_first.sv
// Per-packet length/sum/max collector for a first-marked stream; packets close on
// the next first or on flush, and summaries queue in a 2-entry valid/ready buffer.
module pkt_stats_from_first #(
  parameter int width     = 8,
  parameter int len_width = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         up_valid,
  input  logic                         up_first,
  input  logic [width-1:0]             up_data,
  input  logic                         flush,
  output logic                         down_valid,
  input  logic                         down_ready,
  output logic [len_width-1:0]         down_len,
  output logic [width+len_width-1:0]   down_sum,
  output logic [width-1:0]             down_max,
  output logic                         down_sat,
  output logic                         overflow
);

  localparam int sum_width = width + len_width;
  localparam int rec_width = len_width + sum_width + width + 1;
  localparam logic [len_width-1:0] len_one = {{(len_width-1){1'b0}}, 1'b1};
  localparam logic [len_width-1:0] len_max = {len_width{1'b1}};

  logic                   open_r;
  logic [len_width-1:0]   len_r;
  logic [sum_width-1:0]   sum_r;
  logic [width-1:0]       max_r;
  logic                   sat_r;

  logic [rec_width-1:0]   e0_r, e1_r;
  logic [1:0]             cnt_r;
  logic                   valid_r;
  logic                   ovf_r;

  logic                   start_s, accum_s, close_s, pop_s;
  logic [len_width-1:0]   upd_len_s;
  logic [sum_width-1:0]   upd_sum_s;
  logic [width-1:0]       upd_max_s;
  logic                   upd_sat_s;
  logic [rec_width-1:0]   rec_s;
  logic [rec_width-1:0]   e0_nxt_s, e1_nxt_s;
  logic [1:0]             cnt_nxt_s;
  logic                   ovf_nxt_s;

  // Accumulator update for a continuation word and the record a close would push
  always_comb begin
    start_s   = up_valid & up_first;
    accum_s   = up_valid & ~up_first & open_r;
    close_s   = open_r & (start_s | flush);
    upd_len_s = len_r;
    upd_sum_s = sum_r;
    upd_max_s = max_r;
    upd_sat_s = sat_r;
    if (accum_s) begin
      if (len_r == len_max) begin
        upd_sat_s = 1'b1;
      end else begin
        upd_len_s = len_r + len_one;
        upd_sum_s = sum_r + {{len_width{1'b0}}, up_data};
      end
      if (up_data > max_r) begin
        upd_max_s = up_data;
      end else begin
        upd_max_s = max_r;
      end
    end else begin
      upd_sat_s = sat_r;
    end
    // A first closes the old packet before its own word is counted
    if (start_s) begin
      rec_s = {len_r, sum_r, max_r, sat_r};
    end else begin
      rec_s = {upd_len_s, upd_sum_s, upd_max_s, upd_sat_s};
    end
  end

  // Output buffer next state; the head entry is kept zero whenever the buffer is empty
  always_comb begin
    pop_s     = valid_r & down_ready;
    e0_nxt_s  = e0_r;
    e1_nxt_s  = e1_r;
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_r;
    case (cnt_r)
      2'd0: begin
        if (close_s) begin
          e0_nxt_s  = rec_s;
          cnt_nxt_s = 2'd1;
        end else begin
          cnt_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (pop_s && close_s) begin
          e0_nxt_s = rec_s;
        end else if (pop_s) begin
          e0_nxt_s  = '0;
          cnt_nxt_s = 2'd0;
        end else if (close_s) begin
          e1_nxt_s  = rec_s;
          cnt_nxt_s = 2'd2;
        end else begin
          cnt_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_nxt_s = e1_r;
          if (close_s) begin
            e1_nxt_s = rec_s;
          end else begin
            e1_nxt_s  = '0;
            cnt_nxt_s = 2'd1;
          end
        end else if (close_s) begin
          ovf_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = 2'd2;
        end
      end
      default: begin
        e0_nxt_s  = '0;
        e1_nxt_s  = '0;
        cnt_nxt_s = 2'd0;
      end
    endcase
  end

  // Accumulator registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      open_r <= 1'b0;
      len_r  <= '0;
      sum_r  <= '0;
      max_r  <= '0;
      sat_r  <= 1'b0;
    end else if (start_s) begin
      open_r <= 1'b1;
      len_r  <= len_one;
      sum_r  <= {{len_width{1'b0}}, up_data};
      max_r  <= up_data;
      sat_r  <= 1'b0;
    end else if (close_s) begin
      open_r <= 1'b0;
      len_r  <= '0;
      sum_r  <= '0;
      max_r  <= '0;
      sat_r  <= 1'b0;
    end else begin
      len_r  <= upd_len_s;
      sum_r  <= upd_sum_s;
      max_r  <= upd_max_s;
      sat_r  <= upd_sat_s;
    end
  end

  // Output buffer registers and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e0_r    <= '0;
      e1_r    <= '0;
      cnt_r   <= 2'd0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      e0_r    <= e0_nxt_s;
      e1_r    <= e1_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= (cnt_nxt_s != 2'd0);
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign down_valid = valid_r;
  assign down_len   = e0_r[rec_width-1 -: len_width];
  assign down_sum   = e0_r[width+1 +: sum_width];
  assign down_max   = e0_r[1 +: width];
  assign down_sat   = e0_r[0];
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_pkt_stats_from_first.sv
// Directed self-checking bench for pkt_stats_from_first, with a second narrow
// instance (len_width=2) for length saturation.
module tb_pkt_stats_from_first;

  logic        clock = 1'b0;
  logic        reset;
  logic        up_valid, up_first, flush, down_ready;
  logic [7:0]  up_data;
  logic        down_valid, down_sat, overflow;
  logic [7:0]  down_len, down_max;
  logic [15:0] down_sum;

  logic        s_valid, s_first, s_flush, s_ready;
  logic [7:0]  s_data;
  logic        s_down_valid, s_down_sat, s_overflow;
  logic [1:0]  s_down_len;
  logic [9:0]  s_down_sum;
  logic [7:0]  s_down_max;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pkt_stats_from_first #(.width(8), .len_width(8)) dut (
    .clock(clock), .reset(reset), .up_valid(up_valid), .up_first(up_first),
    .up_data(up_data), .flush(flush), .down_valid(down_valid),
    .down_ready(down_ready), .down_len(down_len), .down_sum(down_sum),
    .down_max(down_max), .down_sat(down_sat), .overflow(overflow)
  );

  pkt_stats_from_first #(.width(8), .len_width(2)) dut_sat (
    .clock(clock), .reset(reset), .up_valid(s_valid), .up_first(s_first),
    .up_data(s_data), .flush(s_flush), .down_valid(s_down_valid),
    .down_ready(s_ready), .down_len(s_down_len), .down_sum(s_down_sum),
    .down_max(s_down_max), .down_sat(s_down_sat), .overflow(s_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_rec(input string tag, input logic v, input int len, input int sum,
                            input int mx, input logic sat);
    check({tag, ".valid"}, {31'd0, down_valid}, {31'd0, v});
    check({tag, ".len"}, {24'd0, down_len}, len);
    check({tag, ".sum"}, {16'd0, down_sum}, sum);
    check({tag, ".max"}, {24'd0, down_max}, mx);
    check({tag, ".sat"}, {31'd0, down_sat}, {31'd0, sat});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [7:0] d, input logic fl);
    up_valid = v; up_first = f; up_data = d; flush = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    down_ready = 1'b1;
    s_valid = 1'b0; s_first = 1'b0; s_data = 8'd0; s_flush = 1'b0; s_ready = 1'b0;
    tick();
    expect_rec("rst", 1'b0, 0, 0, 0, 1'b0);
    check("rst.ovf", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    expect_rec("rst_rel", 1'b0, 0, 0, 0, 1'b0);

    // 3,5,7 then first 1 then flush
    drive(1'b1, 1'b1, 8'd3, 1'b0); tick();
    drive(1'b1, 1'b0, 8'd5, 1'b0); tick();
    drive(1'b1, 1'b0, 8'd7, 1'b0); tick();
    check("t1.noearly", {31'd0, down_valid}, 32'd0);
    drive(1'b1, 1'b1, 8'd1, 1'b0); tick();
    expect_rec("t1.r0", 1'b1, 3, 15, 7, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
    expect_rec("t1.r1", 1'b1, 1, 1, 1, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0); tick();
    expect_rec("t1.empty", 1'b0, 0, 0, 0, 1'b0);

    // orphans dropped
    drive(1'b1, 1'b0, 8'd4, 1'b0); tick();
    drive(1'b1, 1'b0, 8'd9, 1'b1); tick();
    check("t2.orphan", {31'd0, down_valid}, 32'd0);
    drive(1'b1, 1'b1, 8'd2, 1'b0); tick();
    drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
    expect_rec("t2.r0", 1'b1, 1, 2, 2, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0); tick();
    check("t2.empty", {31'd0, down_valid}, 32'd0);

    // back-to-back single-word packets
    drive(1'b1, 1'b1, 8'd1, 1'b0); tick();
    drive(1'b1, 1'b1, 8'd2, 1'b0); tick();
    expect_rec("b2b.r0", 1'b1, 1, 1, 1, 1'b0);
    drive(1'b1, 1'b1, 8'd3, 1'b0); tick();
    expect_rec("b2b.r1", 1'b1, 1, 2, 2, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
    expect_rec("b2b.r2", 1'b1, 1, 3, 3, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0); tick();

    // overflow: three closes with down_ready low
    down_ready = 1'b0;
    drive(1'b1, 1'b1, 8'd10, 1'b0); tick();
    drive(1'b1, 1'b1, 8'd20, 1'b0); tick();
    drive(1'b1, 1'b1, 8'd30, 1'b0); tick();
    check("t3.ovf0", {31'd0, overflow}, 32'd0);
    drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    expect_rec("t3.hold", 1'b1, 1, 10, 10, 1'b0);
    check("t3.ovf1", {31'd0, overflow}, 32'd1);
    tick();
    expect_rec("t3.stable", 1'b1, 1, 10, 10, 1'b0);
    down_ready = 1'b1; tick();
    expect_rec("t3.r1", 1'b1, 1, 20, 20, 1'b0);
    tick();
    expect_rec("t3.empty", 1'b0, 0, 0, 0, 1'b0);
    check("t3.ovfsticky", {31'd0, overflow}, 32'd1);

    // asynchronous reset mid-packet with a buffered record
    down_ready = 1'b0;
    drive(1'b1, 1'b1, 8'd70, 1'b0); tick();
    drive(1'b1, 1'b1, 8'd80, 1'b0); tick();
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    check("t6.pre", {31'd0, down_valid}, 32'd1);
    reset = 1'b0; #1;
    check("t6.valid", {31'd0, down_valid}, 32'd0);
    check("t6.ovf", {31'd0, overflow}, 32'd0);
    check("t6.len", {24'd0, down_len}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'd6, 1'b0); tick();
    drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    expect_rec("t6.r0", 1'b1, 1, 6, 6, 1'b0);
    down_ready = 1'b1; tick();
    check("t6.empty", {31'd0, down_valid}, 32'd0);

    // full buffer then simultaneous push and pop
    down_ready = 1'b0;
    drive(1'b1, 1'b1, 8'd40, 1'b0); tick();
    drive(1'b1, 1'b1, 8'd50, 1'b0); tick();
    drive(1'b1, 1'b1, 8'd60, 1'b0); tick();
    down_ready = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b1); tick();
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    expect_rec("t4.r1", 1'b1, 1, 50, 50, 1'b0);
    check("t4.ovf", {31'd0, overflow}, 32'd0);
    tick();
    expect_rec("t4.r2", 1'b1, 1, 60, 60, 1'b0);
    tick();
    check("t4.empty", {31'd0, down_valid}, 32'd0);

    // saturation with len_width=2
    s_valid = 1'b1; s_first = 1'b1; s_data = 8'd1; tick();
    s_first = 1'b0;
    s_data = 8'd2; tick();
    s_data = 8'd3; tick();
    s_data = 8'd4; tick();
    s_data = 8'd5; tick();
    s_valid = 1'b0; s_data = 8'd0; s_flush = 1'b1; tick();
    s_flush = 1'b0;
    check("t5.valid", {31'd0, s_down_valid}, 32'd1);
    check("t5.len", {30'd0, s_down_len}, 32'd3);
    check("t5.sum", {22'd0, s_down_sum}, 32'd6);
    check("t5.max", {24'd0, s_down_max}, 32'd5);
    check("t5.sat", {31'd0, s_down_sat}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
